// File: rtl/arbiter_mux2ne1_if.sv
// Request/grant bundle between two requesters and the arbiter_mux2ne1 that steers
// the shared 2:1 datapath mux.
interface arbiter_mux2ne1_if;
    // Handshake: a requester raises Kerkesa and keeps it high. Its Leje rises one
    // clock edge later and the grant is exclusive. The requester keeps the grant
    // until it pulses Mbarim or drops Kerkesa. Mbarim is only sampled while the
    // requester holds the grant.
    logic Kerkesa0;
    logic Kerkesa1;
    logic Mbarim0;
    logic Mbarim1;
    logic Leje0;
    logic Leje1;
    logic S;
    logic Zene;
    logic Timeout;

    modport master (
        output Kerkesa0, Kerkesa1, Mbarim0, Mbarim1,
        input  Leje0, Leje1, S, Zene, Timeout
    );

    modport slave (
        input  Kerkesa0, Kerkesa1, Mbarim0, Mbarim1,
        output Leje0, Leje1, S, Zene, Timeout
    );
endinterface

// File: rtl/arbiter_mux2ne1.sv
// Two-requester round-robin arbiter that owns the select of a shared 2:1 mux.
// Optional grant timeout is enabled with `define TIMEOUT_EN.
module arbiter_mux2ne1 #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 8
) (
    input  logic              Clock,
    input  logic              Reset_n,
    arbiter_mux2ne1_if.slave  bus,
    output logic [1:0]        o_dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   r_fundit;
    logic   w_fundit_nxt;
    logic   r_s;
    logic   r_timeout;
    logic   w_timeout;
    logic   w_hit;

`ifdef TIMEOUT_EN
    logic [CNT_W-1:0] r_cnt;

    // Counter restarts on every grant entry, including a direct hand-off.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_cnt <= '0;
        end else if (w_state_nxt != r_state) begin
            r_cnt <= '0;
        end else if ((r_state != IDLE) && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign w_hit = (r_cnt == CNT_W'(MAX_HOLD - 1));
`else
    // The parameters only matter when the timeout is built in.
    assign w_hit = (MAX_HOLD < 1) && (CNT_W < 1);
`endif

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state   <= IDLE;
            r_fundit  <= 1'b1;
            r_s       <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_fundit  <= w_fundit_nxt;
            r_timeout <= w_timeout;
            if (w_state_nxt == G0) begin
                r_s <= 1'b0;
            end else if (w_state_nxt == G1) begin
                r_s <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_fundit_nxt = r_fundit;
        w_timeout    = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.Kerkesa0 && bus.Kerkesa1) begin
                    w_state_nxt = r_fundit ? G0 : G1;
                end else if (bus.Kerkesa0) begin
                    w_state_nxt = G0;
                end else if (bus.Kerkesa1) begin
                    w_state_nxt = G1;
                end
            end
            G0: begin
                w_timeout = w_hit && bus.Kerkesa0 && !bus.Mbarim0;
                if (bus.Mbarim0 || !bus.Kerkesa0 || w_timeout) begin
                    w_fundit_nxt = 1'b0;
                    w_state_nxt  = bus.Kerkesa1 ? G1 : IDLE;
                end
            end
            G1: begin
                w_timeout = w_hit && bus.Kerkesa1 && !bus.Mbarim1;
                if (bus.Mbarim1 || !bus.Kerkesa1 || w_timeout) begin
                    w_fundit_nxt = 1'b1;
                    w_state_nxt  = bus.Kerkesa0 ? G0 : IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign bus.Leje0   = (r_state == G0);
    assign bus.Leje1   = (r_state == G1);
    assign bus.S       = r_s;
    assign bus.Zene    = (r_state == G0) || (r_state == G1);
    assign bus.Timeout = r_timeout;
    assign o_dbg_state = r_state;

endmodule

// File: doc/arbiter_mux2ne1.md
Name: arbiter_mux2ne1

Overview:
- Two-requester round-robin arbiter that owns the select line of a shared 2:1 datapath mux (e.g. register-file write port or memory address source in the 16-bit CPU).
- Requesters raise a request, receive an exclusive grant, and hold it until they signal completion.
- The block drives the mux select `S` so the granted requester's operand reaches the shared resource.
- Sits between the control unit / peripheral requesters and the 2:1 mux instances.

Parameters:
- MAX_HOLD, 8, maximum consecutive cycles a grant may be held; used only when TIMEOUT_EN is defined. Legal range 1..255.
- CNT_W, 8, width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- Clock  input  1  system clock; all state updates on the rising edge.
- Reset_n  input  1  asynchronous, active-low reset.
- Kerkesa0  input  1  request from requester 0.
- Kerkesa1  input  1  request from requester 1.
- Mbarim0  input  1  done/release pulse from requester 0; sampled only while requester 0 holds the grant.
- Mbarim1  input  1  done/release pulse from requester 1; sampled only while requester 1 holds the grant.
- Leje0  output  1  grant to requester 0 (registered).
- Leje1  output  1  grant to requester 1 (registered).
- S  output  1  mux select: 0 selects Hyrja0 (requester 0), 1 selects Hyrja1 (requester 1); registered.
- Zene  output  1  resource busy; equals Leje0 | Leje1.
- Timeout  output  1  one-cycle pulse when a grant is revoked by timeout; constant 0 without TIMEOUT_EN.

Behaviour:
- Reset (async, Reset_n=0):
  - state=IDLE, Leje0=0, Leje1=0, S=0, Zene=0, Timeout=0.
  - Priority pointer Fundit=1, so requester 0 wins the first tie.
  - Hold counter=0.
- Reset asserted mid-grant drops the grant immediately, without waiting for a clock edge.
- States: IDLE, G0, G1. Outputs are decoded from registered state: Leje0=(G0), Leje1=(G1).
- S is registered:
  - Updates to 0 on entry to G0 and to 1 on entry to G1.
  - Holds its last value in IDLE, so the mux output does not glitch.
- IDLE transitions:
  - Kerkesa0 only -> G0.
  - Kerkesa1 only -> G1.
  - Both asserted -> the requester not equal to Fundit.
  - Neither asserted -> stay in IDLE.
- Latency: request sampled at edge N gives grant visible after edge N (1 cycle from request to grant).
- G0 transitions (G1 symmetric):
  - Stay while Kerkesa0=1 and Mbarim0=0.
  - Release when Mbarim0=1 or Kerkesa0=0. On release, set Fundit=0, then:
    - Kerkesa1=1 in the same cycle -> go directly to G1 (no IDLE bubble; S switches on the same edge).
    - Otherwise -> IDLE.
    - Requester 0 re-requesting while releasing does not keep the grant if Kerkesa1=1.
- Mbarim of the non-granted requester is ignored.
- Leje0 and Leje1 are never both 1; the bench checks this invariant every cycle.
- Hold counter:
  - Cleared on every grant entry.
  - Increments each cycle in G0/G1.
  - Saturates at 2^CNT_W-1.
- Zene is combinational from registered state; no combinational path from inputs to outputs.

Optional Feature:
- Macro TIMEOUT_EN.
- When defined:
  - If the hold counter reaches MAX_HOLD-1 while in G0/G1 with no release, the grant is revoked on the next edge.
  - The revocation is handled exactly like a release (Fundit updated, direct hand-off to the other requester if it is requesting).
  - Timeout pulses high for that one cycle.
  - A timed-out requester that keeps Kerkesa high is re-granted only once the other requester is idle.
- When not defined:
  - No timeout; the grant is held indefinitely.
  - Timeout tied to 0.
  - Counter logic is removed.

Test Plan:
- Reset with Kerkesa0=Kerkesa1=1 held, release Reset_n -> first edge: Leje0=1, S=0, Zene=1; Leje1 stays 0.
- G0 held, pulse Mbarim0=1 with Kerkesa1=1 -> next edge: Leje0=0, Leje1=1, S=1, no IDLE cycle between grants.
- Both requesters continuously requesting, each pulses Mbarim after 3 cycles in grant -> grants alternate 0,1,0,1; S toggles; each grant lasts 4 cycles.
- Kerkesa1 alone, then Mbarim1 with no other request -> G1 then IDLE; S stays 1 in IDLE; Zene=0.
- Reset_n driven low between edges during G1 -> Leje1=0, S=0 immediately (before the next Clock edge).
- TIMEOUT_EN, MAX_HOLD=4, Kerkesa0 held, Mbarim0 never asserted, Kerkesa1=1 -> Leje0 high for exactly 4 cycles, Timeout=1 for one cycle, then Leje1=1, S=1.
